// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frame plus one even-parity bit, mid-bit sampling,
// valid/ready output holding register with overwrite-on-overrun.
// Build option: define UART_RX_PARITY_CHECK_EN to enable parity checking.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   UART_RX            - asynchronous serial line, idle high
//   rx_data            - received word
//   rx_data_valid      - rx_data and error flags valid (held until accepted)
//   rx_data_ready      - consumer accepts the word
//   parity_error       - parity bit differed from ^rx_data (0 when disabled)
//   framing_error      - stop bit sampled low
//   rx_overrun         - one-cycle pulse when an unconsumed word is overwritten
module uart_rx #(
    parameter int CLKRATE     = 100000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   UART_RX,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_data_valid,
    input  logic                   rx_data_ready,
    output logic                   parity_error,
    output logic                   framing_error,
    output logic                   rx_overrun
);

    localparam int BIT_MAX = CLKRATE / BAUD;
    localparam int CNT_W   = $clog2(BIT_MAX);
    localparam int DCW     = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_MAX - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BIT_MAX / 2 - 1);
    localparam logic [DCW-1:0]   LAST_BIT = DCW'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic                   sync1;
    logic                   sync2;
    logic                   line_q;
    logic [CNT_W-1:0]       baud_cnt;
    logic [DCW-1:0]         bit_cnt;
    logic [WORD_LENGTH-1:0] shreg;
    logic                   done;
    logic                   stop_err;
`ifdef UART_RX_PARITY_CHECK_EN
    logic                   par_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            line_q        <= 1'b1;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            done          <= 1'b0;
            stop_err      <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            par_bit       <= 1'b0;
`endif
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            sync1      <= UART_RX;
            sync2      <= sync1;
            line_q     <= sync2;
            baud_cnt   <= baud_cnt + 1'b1;
            done       <= 1'b0;
            rx_overrun <= 1'b0;

            unique case (state)
                IDLE: begin
                    // Edge, not level: a line stuck low after a
                    // framing error must rise again before re-arming.
                    if (line_q && !sync2) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= sync2 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        shreg    <= {sync2, shreg[WORD_LENGTH-1:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
`ifdef UART_RX_PARITY_CHECK_EN
                        par_bit  <= sync2;
`endif
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        stop_err <= !sync2;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase

            if (done) begin
                rx_data       <= shreg;
                framing_error <= stop_err;
`ifdef UART_RX_PARITY_CHECK_EN
                parity_error  <= par_bit ^ (^shreg);
`else
                parity_error  <= 1'b0;
`endif
                rx_data_valid <= 1'b1;
                // A word accepted in this same cycle is not lost.
                rx_overrun    <= rx_data_valid && !rx_data_ready;
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed serial frames, scoreboard of expected
// words checked by a negedge monitor, plus directed state checks.
module tb_uart_rx;

    localparam int BIT = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       parity_error;
    logic       framing_error;
    logic       rx_overrun;

    int vectors = 0;
    int miscompares = 0;
    int ovr_cnt = 0;
    int run = 0;
    int last_run = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;

    logic [9:0] sb[$];

    uart_rx #(
        .CLKRATE    (100000000),
        .BAUD       (1000000),
        .WORD_LENGTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .UART_RX      (line),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b, input int n);
        line = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic par,
                        input logic stp);
        logic pe;
`ifdef UART_RX_PARITY_CHECK_EN
        pe = par != (^d);
`else
        pe = 1'b0;
`endif
        sb.push_back({d, pe, !stp});
        bit_out(1'b0, BIT);
        for (int i = 0; i < 8; i++) bit_out(d[i], BIT);
        bit_out(par, BIT);
        bit_out(stp, BIT);
    endtask

    // Monitor: a new word is a rising valid, an overrun, or valid
    // still high after a handshake on the previous edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rx_overrun === 1'b1) ovr_cnt++;
        if (rx_data_valid === 1'b1) begin
            run++;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (rx_data_valid === 1'b1 &&
            (!pv || rx_overrun === 1'b1 || pr)) begin
            chk("unexpected_word", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rx_data", rx_data, e[9:2]);
                chk("parity_error", parity_error, e[1]);
                chk("framing_error", framing_error, e[0]);
            end
        end
        pv = rx_data_valid;
        pr = rx_data_ready;
    end

    initial begin
        rst = 1'b1;
        line = 1'b1;
        rx_data_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_data_valid, 0);
        chk("rst_perr", parity_error, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovr", rx_overrun, 0);
        @(posedge clk);
        #1;
        bit_out(1'b1, 2 * BIT);

        send(8'hA5, 1'b0, 1'b1);
        chk("a5_valid_width", last_run, 1);
        bit_out(1'b1, BIT);

        send(8'h3C, 1'b1, 1'b1);
        bit_out(1'b1, BIT);

        // Stop bit low, then line held low: must not start a frame.
        send(8'h81, 1'b0, 1'b0);
        bit_out(1'b0, 3 * BIT);
        chk("ferr_hold_valid", rx_data_valid, 0);
        bit_out(1'b1, 2 * BIT);
        send(8'h5A, 1'b0, 1'b1);
        bit_out(1'b1, BIT);

        // Short low glitch is rejected.
        bit_out(1'b0, 20);
        bit_out(1'b1, 3 * BIT);
        chk("glitch_valid", rx_data_valid, 0);

        // Back-to-back words with no consumer.
        rx_data_ready = 1'b0;
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovr_count", ovr_cnt, 1);
        chk("ovr_data", rx_data, 8'h22);
        chk("ovr_valid", rx_data_valid, 1);
        @(posedge clk);
        #1;
        rx_data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_clears", rx_data_valid, 0);
        bit_out(1'b1, BIT);

        // Reset in the middle of data bit 3 of 0x55.
        bit_out(1'b0, BIT);
        bit_out(1'b1, BIT);
        bit_out(1'b0, BIT);
        bit_out(1'b1, BIT);
        bit_out(1'b0, BIT / 2);
        rst = 1'b1;
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", rx_data_valid, 0);
        chk("midrst_data", rx_data, 0);
        @(posedge clk);
        #1;
        bit_out(1'b1, 12 * BIT);
        chk("post_rst_valid", rx_data_valid, 0);
        send(8'h0F, 1'b0, 1'b1);
        bit_out(1'b1, 3 * BIT);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
